lamp_fade_driver: RTL
=====================

# lamp_fade_driver

Lamp actuator stage that consumes the on/off command produced by the automatic-lighting controller and drives the physical lamp. It ramps brightness up and down linearly (soft start / soft stop) and outputs a PWM waveform at the commanded level. It reports fade-in-progress and full-on status back to the control side. It sits downstream of the controller's `saida` output, in the same clock domain.

## Interface

Parameters:
- `PWM_BITS`, 8: width of the brightness level and PWM counter. `MAX_LEVEL` = 2^PWM_BITS − 1.
- `FADE_STEP_T`, 20: clock cycles per one-LSB brightness step during a fade. Must be ≥ 1.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_on`, input, 1: lamp command from the controller (1 = lit). Same clock domain; no synchronizer.
- `lamp_pwm`, output, 1: PWM drive to the lamp switch.
- `level`, output, PWM_BITS: current brightness.
- `busy`, output, 1: high while fading in either direction.
- `lamp_full`, output, 1: high while steady at `MAX_LEVEL`.

## Operation

- FSM states are `OFF`, `FADE_IN`, `ON` and `FADE_OUT`.
- **OFF**
  - `level` = 0.
  - `cmd_on`=1 → `FADE_IN`.
- **FADE_IN**
  - `level` increments by 1 on each step-timer terminal.
  - The increment that makes `level`=`MAX_LEVEL` also moves the FSM to `ON` on the same edge.
  - `cmd_on`=0 → `FADE_OUT`. `level` is held (the fade reverses from its current value).
- **ON**
  - `level` = `MAX_LEVEL`.
  - `cmd_on`=0 → `FADE_OUT`.
- **FADE_OUT**
  - `level` decrements by 1 on each terminal.
  - Reaching 0 moves the FSM to `OFF` on the same edge.
  - `cmd_on`=1 → `FADE_IN`, with `level` held.
- **Step timer `step_cnt`**
  - Cleared on every state change.
  - Counts 0..FADE_STEP_T−1 only in the fade states.
  - The terminal is `step_cnt`==FADE_STEP_T−1; it fires the level step and wraps the counter to 0.
  - With FADE_STEP_T=1, the level steps every cycle.
  - A direction change cancels any partial step.
- **PWM**
  - `pwm_cnt` is free-running 0..MAX_LEVEL−1 and wraps to 0, giving a period of MAX_LEVEL cycles.
  - `lamp_pwm` is registered: `lamp_pwm` ← (`pwm_cnt` < `level`).
  - `level`=0 gives constant 0; `level`=MAX_LEVEL gives constant 1.
  - Over one period, the number of high cycles equals `level`.
- `level` never wraps: no increment at MAX, no decrement at 0.
- **Status outputs**
  - `busy` = state ∈ {FADE_IN, FADE_OUT}.
  - `lamp_full` = state==ON.
  - Both are decoded directly from the state register, with no extra latency.
- **Reset** wins over everything. The next cycle shows: state `OFF`, `level`=0, `lamp_pwm`=0, `busy`=0, `lamp_full`=0, `step_cnt`=0, `pwm_cnt`=0, regardless of `cmd_on`.

## Timing

- `cmd_on` rises in cycle t (FSM in `OFF`):
  - state `FADE_IN` and `busy`=1 at t+1;
  - `level`=1 at t+1+FADE_STEP_T;
  - `level`=MAX_LEVEL, `lamp_full`=1 and `busy`=0 at t+1+MAX_LEVEL·FADE_STEP_T.
- Fade-out is symmetric: `OFF` is reached MAX_LEVEL·FADE_STEP_T cycles after entering `FADE_OUT` from `ON`.
- Reversal: the state change is visible at t+1. The first opposite step comes FADE_STEP_T cycles after that.
- `lamp_pwm` lags the (`pwm_cnt`, `level`) pair by one cycle.
- `cmd_on` toggling every cycle is legal. Each change causes a state change and a timer clear, so `level` stays frozen.

## Structure

- Package `lamp_pkg` holds:
  - `typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} lamp_state_t`;
  - a helper constant function for `MAX_LEVEL` from `PWM_BITS`.
- Sub-module `pwm_gen` #(PWM_BITS) holds the free-running counter and the registered compare.
- The top level holds the FSM, the step timer and the level register.

## Test plan

All scenarios use PWM_BITS=4 (MAX_LEVEL=15) and FADE_STEP_T=3 unless noted.

1. Hold `rst` 5 cycles with `cmd_on`=1 → all outputs 0 throughout and 1 cycle after release. `FADE_IN` is entered the following cycle.
2. `cmd_on` 0→1 at cycle 10, held:
   - `busy`=1 at 11;
   - `level`=1 at 14, 2 at 17;
   - `level`=15 with `lamp_full`=1 and `busy`=0 at 56.
3. In `ON` for 40 cycles → `lamp_pwm` constantly 1. After a full fade-out to `OFF` → constantly 0.
4. Drop `cmd_on` when `level`=5 during fade-in:
   - `FADE_OUT` next cycle;
   - `level` stays 5 for 3 cycles, then reaches 4;
   - `OFF` is reached 15 cycles after entering `FADE_OUT`.
   - Re-raise `cmd_on` at `level`=2 → `FADE_IN` resumes from 2.
5. With FADE_STEP_T=15: within a steady-level window, take 15 consecutive `lamp_pwm` samples starting one cycle after `pwm_cnt`==0 → the high count equals `level`. Check every level 1..14.
6. Assert `rst` mid-fade at `level`=7 → the next cycle shows `level`=0, `lamp_pwm`=0, `busy`=0 and state `OFF`.

Source files
------------

// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - shared state encoding and level helpers for the lamp fade driver
package lamp_pkg;

    typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} lamp_state_t;

    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/lamp_fade_driver_pwm_gen.sv
// rtl/lamp_fade_driver_pwm_gen.sv - free-running PWM counter with registered level compare
module pwm_gen
    import lamp_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] level,
    output logic                lamp_pwm
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(max_level(PWM_BITS));

    logic [PWM_BITS-1:0] pwm_cnt;

    // Period is MAX_LEVEL so that level == MAX_LEVEL holds the output high continuously.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt  <= '0;
            lamp_pwm <= 1'b0;
        end else begin
            pwm_cnt  <= (pwm_cnt == MAX_LEVEL - 1'b1) ? '0 : pwm_cnt + 1'b1;
            lamp_pwm <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/lamp_fade_driver.sv
// rtl/lamp_fade_driver.sv - soft start/stop lamp driver: fade FSM, step timer, level register
module lamp_fade_driver
    import lamp_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int FADE_STEP_T = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_on,
    output logic                lamp_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                busy,
    output logic                lamp_full
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(max_level(PWM_BITS));
    localparam int STEP_W = (FADE_STEP_T > 1) ? $clog2(FADE_STEP_T) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_T - 1);

    lamp_state_t       state;
    logic [STEP_W-1:0] step_cnt;
    logic              step_done;

    assign step_done = (step_cnt == STEP_LAST);
    assign busy      = (state == FADE_IN) || (state == FADE_OUT);
    assign lamp_full = (state == ON);

    // A direction change takes priority over a pending step, so toggling cmd_on freezes level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            level    <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                OFF: begin
                    level    <= '0;
                    step_cnt <= '0;
                    if (cmd_on) state <= FADE_IN;
                end
                FADE_IN: begin
                    if (!cmd_on) begin
                        state    <= FADE_OUT;
                        step_cnt <= '0;
                    end else if (step_done) begin
                        step_cnt <= '0;
                        if (level == MAX_LEVEL) begin
                            state <= ON;
                        end else begin
                            level <= level + 1'b1;
                            if (level == MAX_LEVEL - 1'b1) state <= ON;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ON: begin
                    level    <= MAX_LEVEL;
                    step_cnt <= '0;
                    if (!cmd_on) state <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (cmd_on) begin
                        state    <= FADE_IN;
                        step_cnt <= '0;
                    end else if (step_done) begin
                        step_cnt <= '0;
                        if (level == '0) begin
                            state <= OFF;
                        end else begin
                            level <= level - 1'b1;
                            if (level == {{(PWM_BITS-1){1'b0}}, 1'b1}) state <= OFF;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= OFF;
                    step_cnt <= '0;
                end
            endcase
        end
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .level   (level),
        .lamp_pwm(lamp_pwm)
    );

endmodule
